// File: rtl/edge_drnn_pkg.sv
// Shared widths, types and saturation helpers
// for the EdgeDRNN delta matrix-vector engine.
package edge_drnn_pkg;

    localparam int ACT_BW  = 16;
    localparam int W_BW    = 8;
    localparam int PROD_BW = ACT_BW + W_BW;
    localparam int ACC_BW  = 32;
    localparam int ACC_XBW = ACC_BW + 1;
    localparam int SUM_BW  = ACC_BW + 2;

    localparam int INST_BW      = 80;
    localparam int INST_LEN_LSB = 0;
    localparam int INST_LEN_W   = 23;
    localparam int INST_IDX_LSB = 23;
    localparam int INST_IDX_W   = 16;

    typedef struct packed {
        logic [INST_IDX_W-1:0]    idx;
        logic signed [ACT_BW-1:0] delta;
    } nzl_entry_t;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_LOAD,
        S_SCAN,
        S_WAIT,
        S_OUT
    } scan_state_t;

    typedef enum logic [1:0] {
        M_IDLE,
        M_INST,
        M_WGT
    } mac_state_t;

    function automatic logic signed [ACT_BW-1:0] sat_act(
        input logic signed [SUM_BW-1:0] v
    );
        logic [SUM_BW-ACT_BW:0] hi;
        hi = v[SUM_BW-1:ACT_BW-1];
        if (&hi || ~|hi)
            return v[ACT_BW-1:0];
        return v[SUM_BW-1] ? {1'b1, {(ACT_BW-1){1'b0}}}
                           : {1'b0, {(ACT_BW-1){1'b1}}};
    endfunction

    function automatic logic signed [ACC_BW-1:0] sat_acc(
        input logic signed [ACC_XBW-1:0] v
    );
        if (v[ACC_BW] == v[ACC_BW-1])
            return v[ACC_BW-1:0];
        return v[ACC_BW] ? {1'b1, {(ACC_BW-1){1'b0}}}
                         : {1'b0, {(ACC_BW-1){1'b1}}};
    endfunction

endpackage

// File: rtl/edge_drnn_nzl_fifo.sv
// Nonzero-delta queue; a push is accepted while full
// when a pop frees a slot in the same cycle.
module edge_drnn_nzl_fifo
    import edge_drnn_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  nzl_entry_t din,
    input  logic       pop,
    output nzl_entry_t dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    nzl_entry_t     mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [AW:0]    cnt;
    logic           do_push;
    logic           do_pop;

    assign full    = (cnt == CNT_FULL);
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push)
                wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
            if (do_pop)
                rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= din;
    end

endmodule

// File: rtl/edge_drnn.sv
// Delta-network matrix-vector engine: delta-encodes input beats,
// fetches one weight column per nonzero delta, emits gate sums.
module edge_drnn
    import edge_drnn_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7,
    parameter int NUM_PE             = 8,
    parameter int ACT_INT_BW         = 8,
    parameter int ACT_FRA_BW         = 8,
    parameter int W_INT_BW           = 1,
    parameter int W_FRA_BW           = 7,
    parameter int NUM_LAYER_BW       = 2,
    parameter int LAYER_SIZE_BW      = 10,
    parameter int DTH_BW             = 10,
    parameter int NZI_BW             = 16,
    parameter int NZL_FIFO_DEPTH     = 32,
    parameter int INP_SIZE           = 64,
    parameter int HID_SIZE           = 64,
    parameter int DELTA_TH           = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_inp_axis_tvalid,
    output logic                     s_inp_axis_tready,
    input  logic [NUM_PE*ACT_BW-1:0] s_inp_axis_tdata,
    input  logic                     s_inp_axis_tlast,
    input  logic                     s_w_axis_tvalid,
    output logic                     s_w_axis_tready,
    input  logic [NUM_PE*W_BW-1:0]   s_w_axis_tdata,
    input  logic                     s_w_axis_tlast,
    output logic                     m_inst_axis_tvalid,
    input  logic                     m_inst_axis_tready,
    output logic [INST_BW-1:0]       m_inst_axis_tdata,
    output logic                     m_inst_axis_tlast,
    output logic                     m_out_axis_tvalid,
    input  logic                     m_out_axis_tready,
    output logic [NUM_PE*ACT_BW-1:0] m_out_axis_tdata,
    output logic                     m_out_axis_tlast
);

    localparam int CW        = 16;
    localparam int LW        = $clog2(NUM_PE);
    localparam int XI_W      = $clog2(INP_SIZE);
    localparam int COL_LEN   = 3 * HID_SIZE;
    localparam int AI_W      = $clog2(COL_LEN);
    localparam int W_BEATS   = COL_LEN / NUM_PE;
    localparam int OUT_BEATS = HID_SIZE / NUM_PE;
    localparam int CLR_N     = (INP_SIZE > COL_LEN) ? INP_SIZE : COL_LEN;
    localparam int CLR_BEATS = CLR_N / NUM_PE;

    localparam logic [CW-1:0]     W_LAST    = CW'(W_BEATS - 1);
    localparam logic [CW-1:0]     OUT_LAST  = CW'(OUT_BEATS - 1);
    localparam logic [CW-1:0]     CLR_LAST  = CW'(CLR_BEATS - 1);
    localparam logic [LW-1:0]     LANE_LAST = LW'(NUM_PE - 1);
    localparam logic [ACT_BW:0]   TH        = (ACT_BW+1)'(DELTA_TH);

    if (NUM_PE <= 2 || INP_SIZE % NUM_PE != 0
        || HID_SIZE % NUM_PE != 0
        || INP_SIZE > (1 << LAYER_SIZE_BW)
        || HID_SIZE > (1 << LAYER_SIZE_BW)
        || DELTA_TH >= (1 << DTH_BW)
        || NZI_BW != INST_IDX_W
        || ACT_INT_BW + ACT_FRA_BW != ACT_BW
        || W_INT_BW + W_FRA_BW != W_BW
        || C_S_AXI_DATA_WIDTH <= 0
        || C_S_AXI_ADDR_WIDTH <= 0
        || NUM_LAYER_BW <= 0) begin : g_bad_cfg
        $error("edge_drnn: unsupported parameter set");
    end

    logic signed [ACT_BW-1:0] x_ref [INP_SIZE];
    logic signed [ACC_BW-1:0] acc   [COL_LEN];

    scan_state_t state, state_nx;
    mac_state_t  mstate, mstate_nx;

    logic [CW-1:0]             clr_cnt;
    logic [CW-1:0]             beat_cnt;
    logic [CW-1:0]             out_cnt;
    logic [CW-1:0]             wb_cnt;
    logic [LW-1:0]             lane;
    logic [NUM_PE*ACT_BW-1:0]  inp_buf;
    logic                      inp_last;

    logic [XI_W-1:0]           k_x;
    logic signed [ACT_BW-1:0]  x_cur;
    logic signed [ACT_BW-1:0]  xr;
    logic signed [ACT_BW:0]    d;
    logic [ACT_BW:0]           d_abs;
    logic                      need;
    logic                      push_ok;
    logic                      lane_adv;

    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    nzl_entry_t                fifo_din;
    nzl_entry_t                fifo_dout;
    nzl_entry_t                cur;
    logic                      w_fire;

    logic signed [PROD_BW-1:0] prod  [NUM_PE];
    logic signed [ACC_BW-1:0]  acc_nx [NUM_PE];
    logic signed [SUM_BW-1:0]  sum_o [NUM_PE];

    logic unused_tlast;
    assign unused_tlast = s_w_axis_tlast;

    assign s_inp_axis_tready  = rst_n && (state == S_LOAD);
    assign m_out_axis_tvalid  = rst_n && (state == S_OUT);
    assign m_out_axis_tlast   = rst_n && (state == S_OUT)
                              && (out_cnt == OUT_LAST);
    assign m_inst_axis_tvalid = rst_n && (mstate == M_INST);
    assign m_inst_axis_tlast  = 1'b1;
    assign s_w_axis_tready    = rst_n && (mstate == M_WGT);
    assign w_fire = s_w_axis_tvalid && s_w_axis_tready;

    // Delta of the lane currently under the scanner
    always_comb begin
        x_cur = inp_buf[int'(lane)*ACT_BW +: ACT_BW];
        k_x   = XI_W'(int'(beat_cnt)*NUM_PE + int'(lane));
        xr    = x_ref[k_x];
        d     = (ACT_BW+1)'(x_cur) - (ACT_BW+1)'(xr);
        d_abs = d[ACT_BW] ? -d : d;
        need  = (d_abs >= TH);
        fifo_din.idx   = INST_IDX_W'(k_x);
        fifo_din.delta = sat_act(SUM_BW'(d));
    end

    assign fifo_push = (state == S_SCAN) && need;
    assign push_ok   = fifo_push && (!fifo_full || fifo_pop);
    assign lane_adv  = !need || push_ok;

    always_comb begin
        state_nx = state;
        unique case (state)
            S_CLEAR:
                if (clr_cnt == CLR_LAST)
                    state_nx = S_LOAD;
            S_LOAD:
                if (s_inp_axis_tvalid)
                    state_nx = S_SCAN;
            S_SCAN:
                if (lane_adv && lane == LANE_LAST)
                    state_nx = inp_last ? S_WAIT : S_LOAD;
            S_WAIT:
                if (fifo_empty && mstate == M_IDLE)
                    state_nx = S_OUT;
            S_OUT:
                if (m_out_axis_tready && out_cnt == OUT_LAST)
                    state_nx = S_LOAD;
            default: state_nx = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_CLEAR;
            clr_cnt  <= '0;
            beat_cnt <= '0;
            out_cnt  <= '0;
            lane     <= '0;
            inp_buf  <= '0;
            inp_last <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_CLEAR)
                clr_cnt <= clr_cnt + 1'b1;
            if (state == S_LOAD && s_inp_axis_tvalid) begin
                inp_buf  <= s_inp_axis_tdata;
                inp_last <= s_inp_axis_tlast;
                lane     <= '0;
            end
            if (state == S_SCAN && lane_adv) begin
                lane <= lane + 1'b1;
                if (lane == LANE_LAST)
                    beat_cnt <= inp_last ? '0 : beat_cnt + 1'b1;
            end
            if (state == S_OUT && m_out_axis_tready)
                out_cnt <= (out_cnt == OUT_LAST) ? '0 : out_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            for (int p = 0; p < NUM_PE; p++)
                if (int'(clr_cnt)*NUM_PE + p < INP_SIZE)
                    x_ref[XI_W'(int'(clr_cnt)*NUM_PE + p)] <= '0;
        end else if (push_ok) begin
            x_ref[k_x] <= x_cur;
        end
    end

    edge_drnn_nzl_fifo #(
        .DEPTH (NZL_FIFO_DEPTH)
    ) u_nzl_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        mstate_nx = mstate;
        fifo_pop  = 1'b0;
        unique case (mstate)
            M_IDLE:
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    mstate_nx = M_INST;
                end
            M_INST:
                if (m_inst_axis_tready)
                    mstate_nx = M_WGT;
            M_WGT:
                if (w_fire && wb_cnt == W_LAST)
                    mstate_nx = M_IDLE;
            default: mstate_nx = M_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mstate <= M_IDLE;
            wb_cnt <= '0;
            cur    <= '0;
        end else begin
            mstate <= mstate_nx;
            if (fifo_pop)
                cur <= fifo_dout;
            if (w_fire)
                wb_cnt <= (wb_cnt == W_LAST) ? '0 : wb_cnt + 1'b1;
        end
    end

    always_comb begin
        m_inst_axis_tdata = '0;
        m_inst_axis_tdata[INST_LEN_LSB +: INST_LEN_W] =
            INST_LEN_W'(COL_LEN);
        m_inst_axis_tdata[INST_IDX_LSB +: INST_IDX_W] = cur.idx;
    end

    // Q8.8 delta times Q1.7 weight lands in Q9.15
    always_comb begin
        for (int p = 0; p < NUM_PE; p++) begin
            prod[p] = PROD_BW'(cur.delta)
                    * PROD_BW'($signed(
                        s_w_axis_tdata[p*W_BW +: W_BW]));
            acc_nx[p] = sat_acc(
                ACC_XBW'(acc[AI_W'(int'(wb_cnt)*NUM_PE + p)])
                + ACC_XBW'(prod[p]));
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            for (int p = 0; p < NUM_PE; p++)
                if (int'(clr_cnt)*NUM_PE + p < COL_LEN)
                    acc[AI_W'(int'(clr_cnt)*NUM_PE + p)] <= '0;
        end else if (w_fire) begin
            for (int p = 0; p < NUM_PE; p++)
                acc[AI_W'(int'(wb_cnt)*NUM_PE + p)] <= acc_nx[p];
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PE; p++) begin
            sum_o[p] =
                SUM_BW'(acc[AI_W'(int'(out_cnt)*NUM_PE + p)])
              + SUM_BW'(acc[AI_W'(HID_SIZE
                    + int'(out_cnt)*NUM_PE + p)])
              + SUM_BW'(acc[AI_W'(2*HID_SIZE
                    + int'(out_cnt)*NUM_PE + p)]);
            m_out_axis_tdata[p*ACT_BW +: ACT_BW] =
                sat_act(sum_o[p] >>> W_FRA_BW);
        end
    end

endmodule

// File: tb/tb_edge_drnn.sv
// Directed bench for edge_drnn with an 8x8 single-beat configuration.
module tb_edge_drnn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         s_inp_axis_tvalid;
    logic         s_inp_axis_tready;
    logic [127:0] s_inp_axis_tdata;
    logic         s_inp_axis_tlast;
    logic         s_w_axis_tvalid;
    logic         s_w_axis_tready;
    logic [63:0]  s_w_axis_tdata;
    logic         s_w_axis_tlast;
    logic         m_inst_axis_tvalid;
    logic         m_inst_axis_tready;
    logic [79:0]  m_inst_axis_tdata;
    logic         m_inst_axis_tlast;
    logic         m_out_axis_tvalid;
    logic         m_out_axis_tready;
    logic [127:0] m_out_axis_tdata;
    logic         m_out_axis_tlast;

    int checks   = 0;
    int failures = 0;
    int inst_cnt = 0;

    edge_drnn #(
        .NUM_PE   (8),
        .INP_SIZE (8),
        .HID_SIZE (8),
        .DELTA_TH (16)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .s_inp_axis_tvalid  (s_inp_axis_tvalid),
        .s_inp_axis_tready  (s_inp_axis_tready),
        .s_inp_axis_tdata   (s_inp_axis_tdata),
        .s_inp_axis_tlast   (s_inp_axis_tlast),
        .s_w_axis_tvalid    (s_w_axis_tvalid),
        .s_w_axis_tready    (s_w_axis_tready),
        .s_w_axis_tdata     (s_w_axis_tdata),
        .s_w_axis_tlast     (s_w_axis_tlast),
        .m_inst_axis_tvalid (m_inst_axis_tvalid),
        .m_inst_axis_tready (m_inst_axis_tready),
        .m_inst_axis_tdata  (m_inst_axis_tdata),
        .m_inst_axis_tlast  (m_inst_axis_tlast),
        .m_out_axis_tvalid  (m_out_axis_tvalid),
        .m_out_axis_tready  (m_out_axis_tready),
        .m_out_axis_tdata   (m_out_axis_tdata),
        .m_out_axis_tlast   (m_out_axis_tlast)
    );

    always @(posedge clk)
        if (m_inst_axis_tvalid && m_inst_axis_tready)
            inst_cnt <= inst_cnt + 1;

    task automatic send_inp(input logic [127:0] data, input logic last);
        int n = 0;
        s_inp_axis_tdata  = data;
        s_inp_axis_tlast  = last;
        s_inp_axis_tvalid = 1'b1;
        while (!s_inp_axis_tready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!s_inp_axis_tready) begin
            checks++;
            failures++;
            $display("FAIL inp_timeout tready=%b want 1", s_inp_axis_tready);
        end
        @(negedge clk);
        s_inp_axis_tvalid = 1'b0;
        s_inp_axis_tlast  = 1'b0;
    endtask

    task automatic get_inst(output logic [79:0] d);
        int n = 0;
        while (!m_inst_axis_tvalid && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!m_inst_axis_tvalid) begin
            checks++;
            failures++;
            $display("FAIL inst_timeout valid=%b want 1", m_inst_axis_tvalid);
        end
        d = m_inst_axis_tdata;
        @(negedge clk);
    endtask

    task automatic send_w(input logic [63:0] w, input int beats);
        for (int i = 0; i < beats; i++) begin
            int n = 0;
            s_w_axis_tdata  = w;
            s_w_axis_tvalid = 1'b1;
            while (!s_w_axis_tready && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (!s_w_axis_tready) begin
                checks++;
                failures++;
                $display("FAIL w_timeout tready=%b want 1", s_w_axis_tready);
            end
            @(negedge clk);
        end
        s_w_axis_tvalid = 1'b0;
    endtask

    task automatic recv_out(output logic [127:0] d, output logic last);
        int n = 0;
        m_out_axis_tready = 1'b1;
        while (!m_out_axis_tvalid && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!m_out_axis_tvalid) begin
            checks++;
            failures++;
            $display("FAIL out_timeout valid=%b want 1", m_out_axis_tvalid);
        end
        d    = m_out_axis_tdata;
        last = m_out_axis_tlast;
        @(negedge clk);
        m_out_axis_tready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n              = 1'b0;
        s_inp_axis_tvalid  = 1'b0;
        s_inp_axis_tdata   = '0;
        s_inp_axis_tlast   = 1'b0;
        s_w_axis_tvalid    = 1'b0;
        s_w_axis_tdata     = '0;
        s_w_axis_tlast     = 1'b0;
        m_inst_axis_tready = 1'b1;
        m_out_axis_tready  = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (m_out_axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL rst_out_valid got=%b want=0", m_out_axis_tvalid);
        end
        checks++;
        if (m_inst_axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL rst_inst_valid got=%b want=0", m_inst_axis_tvalid);
        end
        checks++;
        if (s_inp_axis_tready !== 1'b0) begin
            failures++;
            $display("FAIL rst_inp_ready got=%b want=0", s_inp_axis_tready);
        end
        checks++;
        if (s_w_axis_tready !== 1'b0) begin
            failures++;
            $display("FAIL rst_w_ready got=%b want=0", s_w_axis_tready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_inp_axis_tready !== 1'b0) begin
            failures++;
            $display("FAIL clear_inp_ready got=%b want=0", s_inp_axis_tready);
        end
    endtask

    task automatic test_zero();
        logic [127:0] d;
        logic         l;
        int           base = inst_cnt;
        send_inp('0, 1'b1);
        recv_out(d, l);
        checks++;
        if (d !== 128'h0) begin
            failures++;
            $display("FAIL zero_data got=%h want=0", d);
        end
        checks++;
        if (l !== 1'b1) begin
            failures++;
            $display("FAIL zero_tlast got=%b want=1", l);
        end
        checks++;
        if (inst_cnt !== base) begin
            failures++;
            $display("FAIL zero_inst got=%0d want=%0d", inst_cnt, base);
        end
    endtask

    task automatic test_single();
        logic [79:0]  i;
        logic [127:0] d;
        logic         l;
        send_inp(128'h0100, 1'b1);
        get_inst(i);
        checks++;
        if (i[22:0] !== 23'd24) begin
            failures++;
            $display("FAIL inst_len got=%0d want=24", i[22:0]);
        end
        checks++;
        if (i[38:23] !== 16'd0) begin
            failures++;
            $display("FAIL inst_idx got=%0d want=0", i[38:23]);
        end
        checks++;
        if (i[79:39] !== 41'd0) begin
            failures++;
            $display("FAIL inst_hi got=%h want=0", i[79:39]);
        end
        send_w({8{8'h40}}, 3);
        recv_out(d, l);
        checks++;
        if (d !== {8{16'h0180}}) begin
            failures++;
            $display("FAIL single_data got=%h want=%h", d, {8{16'h0180}});
        end
        checks++;
        if (l !== 1'b1) begin
            failures++;
            $display("FAIL single_tlast got=%b want=1", l);
        end
    endtask

    task automatic test_no_delta(input logic [127:0] x, input string nm);
        logic [127:0] d;
        logic         l;
        int           base = inst_cnt;
        send_inp(x, 1'b1);
        recv_out(d, l);
        checks++;
        if (d !== {8{16'h0180}}) begin
            failures++;
            $display("FAIL %s_data got=%h want=%h", nm, d, {8{16'h0180}});
        end
        checks++;
        if (inst_cnt !== base) begin
            failures++;
            $display("FAIL %s_inst got=%0d want=%0d", nm, inst_cnt, base);
        end
    endtask

    task automatic test_saturate();
        logic [79:0]  i;
        logic [127:0] held;
        logic [127:0] d;
        logic         l;
        int           n = 0;
        m_out_axis_tready = 1'b0;
        send_inp({8{16'h7FFF}}, 1'b1);
        for (int k = 0; k < 8; k++) begin
            get_inst(i);
            checks++;
            if (i[38:23] !== 16'(k)) begin
                failures++;
                $display("FAIL sat_idx got=%0d want=%0d", i[38:23], k);
            end
            send_w({8{8'h7F}}, 3);
        end
        while (!m_out_axis_tvalid && n < 500) begin
            @(negedge clk);
            n++;
        end
        held = m_out_axis_tdata;
        checks++;
        if (held !== {8{16'h7FFF}}) begin
            failures++;
            $display("FAIL sat_data got=%h want=%h", held, {8{16'h7FFF}});
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (m_out_axis_tvalid !== 1'b1 || m_out_axis_tdata !== held) begin
                failures++;
                $display("FAIL hold_stable v=%b got=%h want=%h",
                         m_out_axis_tvalid, m_out_axis_tdata, held);
            end
        end
        recv_out(d, l);
        checks++;
        if (l !== 1'b1) begin
            failures++;
            $display("FAIL sat_tlast got=%b want=1", l);
        end
    endtask

    task automatic test_reset_mid();
        logic [79:0]  i;
        logic [127:0] d;
        logic         l;
        int           base;
        send_inp('0, 1'b1);
        get_inst(i);
        checks++;
        if (i[38:23] !== 16'd0) begin
            failures++;
            $display("FAIL mid_idx got=%0d want=0", i[38:23]);
        end
        send_w({8{8'h11}}, 1);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (m_inst_axis_tvalid !== 1'b0 || m_out_axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_valid inst=%b out=%b want=0",
                     m_inst_axis_tvalid, m_out_axis_tvalid);
        end
        checks++;
        if (s_w_axis_tready !== 1'b0 || s_inp_axis_tready !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_ready w=%b inp=%b want=0",
                     s_w_axis_tready, s_inp_axis_tready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_inp_axis_tready !== 1'b0) begin
            failures++;
            $display("FAIL mid_clear_ready got=%b want=0", s_inp_axis_tready);
        end
        base = inst_cnt;
        send_inp('0, 1'b1);
        recv_out(d, l);
        checks++;
        if (d !== 128'h0) begin
            failures++;
            $display("FAIL mid_zero_data got=%h want=0", d);
        end
        checks++;
        if (l !== 1'b1) begin
            failures++;
            $display("FAIL mid_zero_tlast got=%b want=1", l);
        end
        checks++;
        if (inst_cnt !== base) begin
            failures++;
            $display("FAIL mid_zero_inst got=%0d want=%0d", inst_cnt, base);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_single();
        test_no_delta(128'h0100, "repeat");
        test_no_delta(128'h0108, "small");
        test_saturate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
